// File: rtl/key_snapshot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_snapshot_ctrl                                                          |
// | Sweeps debounced keys into the key RAM and serves frozen SPI byte reads.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module key_snapshot_ctrl #(
    parameter int         NUM_KEYS    = 61,
    parameter logic [8:0] STATUS_ADDR = 9'h1FF
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                spi_cs_i,
    input  logic                rd_req_i,
    input  logic [8:0]          rd_addr_i,
    output logic                rd_ack_o,
    output logic [7:0]          rd_data_o,
    output logic                ram_we_o,
    output logic [8:0]          ram_addr_o,
    output logic [7:0]          ram_wdata_o,
    input  logic [7:0]          ram_rdata_i,
    output logic                frozen_o
);

    localparam int         GROUPS     = (NUM_KEYS + 7) / 8;
    localparam int         PAD_W      = GROUPS * 8;
    localparam logic [8:0] LAST_GROUP = 9'(GROUPS - 1);
    localparam logic [8:0] NUM_GROUPS = 9'(GROUPS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SWEEP   = 3'd1;
    localparam logic [2:0] ST_FROZEN  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RD_DONE = 3'd4;

    logic [2:0]          state_q,     state_d;
    logic [NUM_KEYS-1:0] snap_q,      snap_d;
    logic [NUM_KEYS-1:0] last_snap_q, last_snap_d;
    logic                change_q,    change_d;
    logic [8:0]          g_q,         g_d;
    logic [8:0]          rd_addr_q,   rd_addr_d;
    logic [7:0]          rd_data_q,   rd_data_d;

    logic [PAD_W-1:0]    padded_w;
    logic [7:0]          group_w;
    logic                accept_w;

    generate
        if (PAD_W > NUM_KEYS) begin : g_pad
            assign padded_w = {{(PAD_W - NUM_KEYS){1'b0}}, snap_q};
        end else begin : g_nopad
            assign padded_w = snap_q;
        end
    endgenerate

    always_comb begin
        group_w = 8'h00;
        for (int i = 0; i < GROUPS; i++) begin
            if (g_q == 9'(i)) begin
                group_w = padded_w[i*8 +: 8];
            end
        end
    end

    // Chip-select release wins over a read request pending in the same cycle.
    assign accept_w = (state_q == ST_FROZEN) && !spi_cs_i && rd_req_i;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        last_snap_d = last_snap_q;
        change_d    = change_q;
        g_d         = g_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!spi_cs_i) begin
                    state_d = ST_FROZEN;
                end else begin
                    snap_d      = keys_i;
                    last_snap_d = keys_i;
                    if (keys_i != last_snap_q) begin
                        change_d = 1'b1;
                    end
                    g_d     = 9'd0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (g_q == LAST_GROUP) begin
                    state_d = ST_IDLE;
                end else begin
                    g_d = g_q + 9'd1;
                end
            end
            ST_FROZEN: begin
                if (spi_cs_i) begin
                    state_d = ST_IDLE;
                end else if (rd_req_i) begin
                    rd_addr_d = rd_addr_i;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_addr_q < NUM_GROUPS) begin
                    rd_data_d = ram_rdata_i;
                end else if (rd_addr_q == STATUS_ADDR) begin
                    rd_data_d = {7'b0, change_q};
                    change_d  = 1'b0;
                end else begin
                    rd_data_d = 8'h00;
                end
                state_d = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                state_d = ST_FROZEN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            last_snap_q <= '0;
            change_q    <= 1'b0;
            g_q         <= 9'd0;
            rd_addr_q   <= 9'd0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            last_snap_q <= last_snap_d;
            change_q    <= change_d;
            g_q         <= g_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Outputs decode straight from state so an asserted reset zeroes them at once.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = 9'd0;
        ram_wdata_o = 8'h00;
        if (state_q == ST_SWEEP) begin
            ram_we_o    = 1'b1;
            ram_addr_o  = g_q;
            ram_wdata_o = group_w;
        end else if (accept_w) begin
            ram_addr_o  = rd_addr_i;
        end
    end

    assign rd_ack_o  = (state_q == ST_RD_DONE);
    assign rd_data_o = rd_data_q;
    assign frozen_o  = (state_q == ST_FROZEN) || (state_q == ST_RD_WAIT) ||
                       (state_q == ST_RD_DONE);

endmodule
`default_nettype wire

// File: tb/tb_key_snapshot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_snapshot_ctrl                                                       |
// | Randomized self-checking bench with a transaction-level key/RAM model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_key_snapshot_ctrl;

    localparam int         NUM_KEYS    = 61;
    localparam int         GROUPS      = (NUM_KEYS + 7) / 8;
    localparam logic [8:0] STATUS_ADDR = 9'h1FF;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NUM_KEYS-1:0] keys;
    logic                cs;
    logic                rd_req;
    logic [8:0]          rd_addr;
    logic                rd_ack;
    logic [7:0]          rd_data;
    logic                ram_we;
    logic [8:0]          ram_addr;
    logic [7:0]          ram_wdata;
    logic [7:0]          ram_rdata;
    logic                frozen;

    always #5 clk = ~clk;

    key_snapshot_ctrl #(.NUM_KEYS(NUM_KEYS), .STATUS_ADDR(STATUS_ADDR)) dut (
        .clk_g_i     (clk),
        .rstn_g_i    (rstn),
        .keys_i      (keys),
        .spi_cs_i    (cs),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_ack_o    (rd_ack),
        .rd_data_o   (rd_data),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .frozen_o    (frozen)
    );

    // Single-port synchronous-read RAM seen by the controller.
    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Key level sampled at each rising edge, indexed by the cycle it closes.
    int                  cyc = 0;
    logic [NUM_KEYS-1:0] keys_hist [64];
    always @(posedge clk) begin
        keys_hist[cyc & 63] = keys;
        cyc = cyc + 1;
    end

    int                  n_checks = 0;
    int                  n_errors = 0;
    logic [7:0]          model_ram [GROUPS];
    logic [NUM_KEYS-1:0] prev_snap_m;
    logic                change_m;
    logic                prev_we;
    logic [8:0]          prev_addr;
    logic [7:0]          last_rd;
    bit                  ack_allowed;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] group_of(input logic [NUM_KEYS-1:0] k, input int g);
        logic [GROUPS*8-1:0] p;
        p = '0;
        p[NUM_KEYS-1:0] = k;
        return p[g*8 +: 8];
    endfunction

    // Sweep and bus-protocol observer, evaluated once per cycle.
    task automatic monitor();
        int                  g;
        logic [NUM_KEYS-1:0] snap;
        logic [7:0]          exp;
        if (!rstn) return;
        if (rd_ack) check_eq("ack_expected", ack_allowed, 1);
        if (ram_we) begin
            g = int'(ram_addr);
            if (g >= GROUPS) begin
                check_eq("wr_addr_range", ram_addr, 0);
            end else begin
                snap = keys_hist[(cyc - g - 1) & 63];
                exp  = group_of(snap, g);
                check_eq("wr_data", ram_wdata, exp);
                model_ram[g] = exp;
                if (g == 0) begin
                    check_eq("sweep_start", prev_we, 0);
                    if (snap != prev_snap_m) change_m = 1'b1;
                    prev_snap_m = snap;
                end else begin
                    check_eq("sweep_order", {prev_we, prev_addr}, {1'b1, 9'(g - 1)});
                end
            end
        end else begin
            if (prev_we) check_eq("sweep_end", prev_addr, GROUPS - 1);
            if (ram_addr != 9'd0)
                check_eq("stray_addr", frozen && rd_req && !cs && (ram_addr == rd_addr), 1);
        end
        prev_we   = ram_we;
        prev_addr = ram_addr;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        #1;
    endtask

    task automatic reset_model();
        prev_snap_m = '0;
        change_m    = 1'b0;
        prev_we     = 1'b0;
        prev_addr   = 9'd0;
        last_rd     = 8'h00;
        ack_allowed = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, {rd_ack, rd_data, ram_we, ram_addr, ram_wdata, frozen}, 0);
    endtask

    task automatic wait_write(input int g);
        int n = 0;
        while (!(ram_we && ram_addr == 9'(g)) && n < 4 * GROUPS) begin
            tick();
            n++;
        end
        check_eq("wait_write_found", ram_we && ram_addr == 9'(g), 1);
    endtask

    task automatic freeze(output int lat);
        int exp_lat;
        exp_lat = ram_we ? (GROUPS + 1 - int'(ram_addr)) : 1;
        cs  = 1'b0;
        lat = 0;
        while (!frozen && lat < 3 * GROUPS) begin
            tick();
            lat++;
        end
        check_eq("freeze_latency", lat, exp_lat);
    endtask

    task automatic unfreeze();
        cs = 1'b1;
        tick();
        check_eq("unfreeze_frozen", frozen, 0);
        check_eq("unfreeze_idle_we", ram_we, 0);
        tick();
        check_eq("unfreeze_sweep", {ram_we, ram_addr}, {1'b1, 9'd0});
    endtask

    task automatic do_read(input logic [8:0] addr, output logic [7:0] data);
        logic [7:0] exp;
        int         lat;
        check_eq("rd_hold", rd_data, last_rd);
        check_eq("rd_frozen", frozen, 1);
        if (int'(addr) < GROUPS) begin
            exp = model_ram[int'(addr)];
        end else if (addr == STATUS_ADDR) begin
            exp      = {7'b0, change_m};
            change_m = 1'b0;
        end else begin
            exp = 8'h00;
        end
        rd_req      = 1'b1;
        rd_addr     = addr;
        ack_allowed = 1'b1;
        #1;
        check_eq("rd_ram_addr", {ram_we, ram_addr}, {1'b0, addr});
        lat = 0;
        while (!rd_ack && lat < 10) begin
            tick();
            lat++;
        end
        check_eq("rd_latency", lat, 2);
        check_eq("rd_data", rd_data, exp);
        data        = rd_data;
        last_rd     = exp;
        rd_req      = 1'b0;
        ack_allowed = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         last0;
        int         acks;
        int         stray;
        logic [7:0] d;
        logic [7:0] d0;
        logic [7:0] mask;
        logic [8:0] a;
        logic [63:0] r64;
        int         idx;

        keys = '0; cs = 1'b1; rd_req = 1'b0; rd_addr = 9'd0; rstn = 1'b0;
        reset_model();
        repeat (3) tick();
        check_outputs_zero("reset_outputs");
        rstn = 1'b1;

        // Free-running sweeps with all keys released.
        last0 = -1;
        repeat (30) begin
            tick();
            check_eq("idle_frozen", frozen, 0);
            if (ram_we && ram_addr == 9'd0) begin
                if (last0 >= 0) check_eq("sweep_period", cyc - last0, GROUPS + 1);
                last0 = cyc;
            end
        end

        // Outermost keys reach groups 0 and 7.
        keys = '0;
        keys[0] = 1'b1;
        keys[60] = 1'b1;
        repeat (2 * (GROUPS + 1)) tick();
        freeze(lat);
        do_read(9'd0, d);
        check_eq("corner_addr0", d, 8'h01);
        do_read(9'd7, d);
        check_eq("corner_addr7", d, 8'h10);
        unfreeze();

        // Chip-select falls during the third sweep cycle.
        wait_write(2);
        freeze(lat);
        check_eq("late_freeze_lat", lat, 7);
        do_read(9'd0, d0);
        r64 = {$urandom, $urandom};
        keys = r64[NUM_KEYS-1:0];
        repeat (5) tick();
        do_read(9'd0, d);
        check_eq("frozen_reread", d, d0);
        unfreeze();

        // Sticky change flag around a single key toggle.
        repeat (2 * (GROUPS + 1)) tick();
        freeze(lat);
        do_read(STATUS_ADDR, d);
        unfreeze();
        repeat (2 * (GROUPS + 1)) tick();
        keys[5] = ~keys[5];
        repeat (2 * (GROUPS + 1)) tick();
        freeze(lat);
        do_read(STATUS_ADDR, d);
        check_eq("status_set", d, 8'h01);
        do_read(STATUS_ADDR, d);
        check_eq("status_cleared", d, 8'h00);
        do_read(9'h020, d);
        check_eq("unmapped_read", d, 8'h00);
        unfreeze();

        // Requests while chip-select is high are ignored.
        rd_req = 1'b1;
        rd_addr = 9'h0AB;
        acks = 0;
        stray = 0;
        repeat (50) begin
            tick();
            if (rd_ack) acks++;
            if (!ram_we && ram_addr != 9'd0) stray++;
        end
        check_eq("cs_high_acks", acks, 0);
        check_eq("cs_high_stray", stray, 0);
        rd_req = 1'b0;
        rd_addr = 9'd0;

        // Reset asserted in the middle of a sweep.
        wait_write(3);
        rstn = 1'b0;
        #1;
        check_outputs_zero("midsweep_reset_outputs");
        reset_model();
        repeat (2) tick();
        rstn = 1'b1;
        mask = 8'h00;
        idx = 0;
        while (mask[7] == 1'b0 && idx < 3 * GROUPS) begin
            tick();
            idx++;
            if (ram_we && int'(ram_addr) < GROUPS) mask[ram_addr[2:0]] = 1'b1;
        end
        check_eq("post_reset_sweep", mask, 8'hFF);

        // Randomized sweep / freeze / read sessions.
        for (int it = 0; it < 16; it++) begin
            r64 = {$urandom, $urandom};
            keys = r64[NUM_KEYS-1:0];
            repeat ($urandom_range(1, 25)) begin
                tick();
                if ($urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, NUM_KEYS - 1);
                    keys[idx] = ~keys[idx];
                end
            end
            freeze(lat);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                case ($urandom_range(0, 3))
                    0, 1:    a = 9'($urandom_range(0, GROUPS - 1));
                    2:       a = STATUS_ADDR;
                    default: a = 9'($urandom_range(0, 511));
                endcase
                if ($urandom_range(0, 1) == 1) begin
                    r64 = {$urandom, $urandom};
                    keys = r64[NUM_KEYS-1:0];
                end
                do_read(a, d);
                if ($urandom_range(0, 2) == 0) tick();
            end
            unfreeze();
        end

        repeat (GROUPS + 2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
